// File: rtl/hazard_unit.sv
// hazard_unit: load-use/branch hazard detector with slow-memory freeze and sticky timeout error.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
`default_nettype none

module hazard_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] ifid_rs1_i,
  input  logic [4:0] ifid_rs2_i,
  input  logic       ifid_use_rs1_i,
  input  logic       ifid_use_rs2_i,
  input  logic [4:0] idex_rd_i,
  input  logic       idex_MemR_i,
  input  logic       branch_taken_i,
  input  logic       mem_req_i,
  input  logic       mem_ready_i,
  output logic       hazard_o,
  output logic       pc_write_o,
  output logic       ifid_write_o,
  output logic       ifid_flush_o,
  output logic       freeze_o,
  output logic       wb_bubble_o,
  output logic       mem_err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic             branch_pend;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err;

  logic mem_stall;
  logic load_use;
  logic flush_now;
  logic bubble_now;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign load_use  = idex_MemR_i & (idex_rd_i != 5'd0) &
                     ((ifid_use_rs1_i & (ifid_rs1_i == idex_rd_i)) |
                      (ifid_use_rs2_i & (ifid_rs2_i == idex_rd_i)));

  // A pending branch replays its flush on the first unfrozen cycle.
  assign flush_now  = ~mem_stall & (branch_taken_i | branch_pend);
  assign bubble_now = ~mem_stall & ~flush_now & load_use;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= RUN;
      branch_pend <= 1'b0;
      wait_cnt    <= '0;
      mem_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (mem_stall) begin
        branch_pend <= branch_pend | branch_taken_i;
        if (wait_cnt != TIMEOUT_C)
          wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        branch_pend <= 1'b0;
        wait_cnt    <= '0;
      end
      if (wait_cnt == TIMEOUT_C)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_stall)  state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem_stall) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    hazard_o     = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    freeze_o     = 1'b0;
    wb_bubble_o  = 1'b0;
    mem_err_o    = mem_err;
    if (rst_i) begin
      hazard_o     = 1'b1;
      ifid_flush_o = 1'b1;
      wb_bubble_o  = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      mem_err_o    = 1'b0;
    end else if (mem_stall) begin
      freeze_o     = 1'b1;
      wb_bubble_o  = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end else if (flush_now) begin
      ifid_flush_o = 1'b1;
      hazard_o     = 1'b1;
    end else if (load_use) begin
      hazard_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (mem_stall)  stall_cnt_o  <= stall_cnt_o + 32'd1;
      if (flush_now)  flush_cnt_o  <= flush_cnt_o + 32'd1;
      if (bubble_now) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard detector and stall/flush sequencer for the 5-stage RISC-V core.
- Drives `hazard_o` into the ID-stage control mux, which zeroes the ID/EX control word when `hazard_o`=1.
- Also drives PC/IF-ID write enables, IF/ID flush, a whole-pipe freeze for slow data memory, and a sticky memory-timeout error.

Parameters:
- MEM_TIMEOUT, 16: consecutive stalled memory cycles before `mem_err_o` sets (legal range 2..255).
- CNT_W, 8: width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ifid_rs1_i  in  5  rs1 of instruction in ID.
- ifid_rs2_i  in  5  rs2 of instruction in ID.
- ifid_use_rs1_i  in  1  ID instruction reads rs1.
- ifid_use_rs2_i  in  1  ID instruction reads rs2.
- idex_rd_i  in  5  destination register of instruction in EX.
- idex_MemR_i  in  1  instruction in EX is a load.
- branch_taken_i  in  1  one-cycle pulse: branch/jump in EX resolved taken.
- mem_req_i  in  1  MEM stage has a valid load/store.
- mem_ready_i  in  1  data memory completes this cycle.
- hazard_o  out  1  insert bubble into ID/EX (to control mux).
- pc_write_o  out  1  PC register load enable.
- ifid_write_o  out  1  IF/ID register load enable.
- ifid_flush_o  out  1  IF/ID load NOP.
- freeze_o  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- wb_bubble_o  out  1  MEM/WB loads bubble (RegWEn=0).
- mem_err_o  out  1  sticky memory-timeout flag.

Behaviour:
- Internal signals:
  - mem_stall = mem_req_i & ~mem_ready_i.
  - load_use = idex_MemR_i & (idex_rd_i != 0) & ((ifid_use_rs1_i & rs1 == rd) | (ifid_use_rs2_i & rs2 == rd)).
- State: FSM {RUN, MEM_WAIT}, branch_pend (1b), wait_cnt (CNT_W), mem_err (1b).
- Outputs are combinational from state/registers/inputs. Default values: pc_write=1, ifid_write=1, others 0.
- Priority, evaluated every cycle (rst_i=0), highest first:
  1. mem_stall: freeze_o=1, wb_bubble_o=1, pc_write_o=0, ifid_write_o=0, hazard_o=0, ifid_flush_o=0. If branch_taken_i=1, set branch_pend next cycle.
  2. branch_taken_i | branch_pend: ifid_flush_o=1, hazard_o=1, pc_write_o=1 (target load), ifid_write_o=1. Clear branch_pend next cycle.
  3. load_use: hazard_o=1, pc_write_o=0, ifid_write_o=0. Exactly one bubble per load-use pair, because the next cycle the load is in MEM.
  4. Otherwise: defaults.
- Branch flush and load-use in the same cycle: flush wins. The ID instruction is discarded, so no stall.
- FSM transitions:
  - RUN→MEM_WAIT on mem_stall.
  - MEM_WAIT→RUN on ~mem_stall. The mem_ready_i=1 cycle is unfrozen and evaluated normally.
- wait_cnt:
  - +1 each cycle mem_stall=1, saturating at MEM_TIMEOUT.
  - Cleared to 0 any cycle mem_stall=0.
  - When wait_cnt reaches MEM_TIMEOUT, mem_err sets on the next edge and stays set until reset.
  - Pipeline remains frozen regardless of the error.
- Reset (rst_i=1 at an edge):
  - State: state=RUN, branch_pend=0, wait_cnt=0, mem_err=0.
  - Outputs while rst_i=1: hazard_o=1, ifid_flush_o=1, wb_bubble_o=1, pc_write_o=0, ifid_write_o=0, freeze_o=0, mem_err_o=0.
  - Reset during MEM_WAIT abandons the wait; no pending flush survives.
- x0 destination never causes a load-use stall.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt_o[31:0], flush_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o counts freeze cycles, flush_cnt_o counts ifid_flush cycles, bubble_cnt_o counts load-use bubbles.
  - All three are cleared on reset and wrap at 2^32.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Load-use: idex_MemR=1, idex_rd=5, ifid_rs1=5, use_rs1=1 → for exactly 1 cycle hazard_o=1, pc_write_o=0, ifid_write_o=0; next cycle (MemR=0) all defaults.
- x0 / unused operand: idex_rd=0 with rs1=0; and rd=7, rs2=7, use_rs2=0 → hazard_o=0 in both cases.
- Branch vs load-use: branch_taken_i=1 with a load-use match → ifid_flush_o=1, hazard_o=1, pc_write_o=1.
- Memory stall with branch: mem_req=1, mem_ready=0 for 3 cycles, branch_taken_i pulsed in cycle 1 → freeze_o=1, wb_bubble_o=1 for 3 cycles. In the ready cycle, ifid_flush_o=1 (pending branch); the following cycle has no flush.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles → mem_err_o rises after the 5th edge and stays 1 after ready; clears only on rst_i.
- Reset mid-wait: rst_i during MEM_WAIT with branch_pend=1 → the cycle after reset has no flush and wait_cnt=0. With HAZARD_PERF_CNT_EN, all counters read 0.
